// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: default bit period and the
// receive FSM state encoding.
package uart_rx_pkg;

    localparam int SERIAL_WCNT          = 16;
    localparam int DEFAULT_CLKS_PER_BIT = SERIAL_WCNT;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_START = 2'd1;
    localparam logic [1:0] STATE_DATA  = 2'd2;
    localparam logic [1:0] STATE_STOP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = STATE_IDLE,
        ST_START = STATE_START,
        ST_DATA  = STATE_DATA,
        ST_STOP  = STATE_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO. A push while full succeeds only when a pop
// happens in the same cycle; otherwise it is ignored.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             wr_en;
    logic             rd_en;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // Power-of-two depth: pointers wrap naturally at AW bits.
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_en && !rd_en)      level_d = level_q + 1'b1;
        else if (rd_en && !wr_en) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM and a
// receive FIFO with frame-error and overrun pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic [7:0]                    data_out,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          rx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

    rx_state_e     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          sync1_q, sync2_q, prev_q;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;

    assign data_valid = !fifo_empty;
    assign pop        = data_valid && data_ready;
    assign rx_busy    = (state_q != ST_IDLE);
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                // Edge, not level: a line stuck low never retriggers.
                if (prev_q && !sync2_q) state_d = ST_START;
            end
            ST_START: begin
                if (timer_q == HALF_M1) begin
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = sync2_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (timer_q == FULL_M1) begin
                    timer_d   = '0;
                    shift_d   = {sync2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (timer_q == FULL_M1) begin
                    timer_d     = '0;
                    state_d     = ST_IDLE;
                    push        = sync2_q;
                    frame_err_d = !sync2_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        overrun_d = push && fifo_full && !pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= rx;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (shift_q),
        .pop       (pop),
        .pop_data  (data_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks/bit with a 4-entry FIFO.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;
    logic [2:0] level;

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .rx_busy    (rx_busy),
        .level      (level)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] tx;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];

    // Snapshots at negedges 154..159 after the start bit is driven.
    logic       snap_valid [6];
    logic [7:0] snap_data  [6];
    logic [2:0] snap_level [6];
    logic       snap_busy  [6];
    logic       snap_ferr  [6];
    logic       snap_ovr   [6];
    int         ferr_cnt;
    int         ovr_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=%0h req=%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int ready_idx);
        ferr_cnt = 0;
        ovr_cnt  = 0;
        for (int i = 0; i < 160; i++) begin
            if (i >= 154) begin
                snap_valid[i-154] = data_valid;
                snap_data[i-154]  = data_out;
                snap_level[i-154] = level;
                snap_busy[i-154]  = rx_busy;
                snap_ferr[i-154]  = frame_err;
                snap_ovr[i-154]   = overrun;
            end
            ferr_cnt += int'(frame_err);
            ovr_cnt  += int'(overrun);
            if (i == ready_idx) data_ready = 1'b1;
            if (i < 16)       rx = 1'b0;
            else if (i < 144) rx = b[3'((i - 16) / 16)];
            else              rx = stop;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        for (int i = 0; i < n; i++) begin
            ferr_cnt += int'(frame_err);
            ovr_cnt  += int'(overrun);
            @(negedge clk);
        end
    endtask

    task automatic pop_one();
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(data_valid), 32'd0);
        chk({tag, "_data"},  32'(data_out),   32'd0);
        chk({tag, "_level"}, 32'(level),      32'd0);
        chk({tag, "_busy"},  32'(rx_busy),    32'd0);
        chk({tag, "_ferr"},  32'(frame_err),  32'd0);
        chk({tag, "_ovr"},   32'(overrun),    32'd0);
    endtask

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 0};
        vecs[1] = '{8'hA3, 1'b0, 1'b0, 8'h00, 1};
        vecs[2] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 0};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};
        vecs[6] = '{8'h01, 1'b0, 1'b0, 8'h00, 1};

        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        $display("[TB] reset: valid=%0b level=%0d busy=%0b", data_valid, level, rx_busy);
        rst_n = 1'b1;
        idle(8);

        // Single frames, each popped before the next.
        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].tx, vecs[v].stop, -1);
            chk("pre_valid",   32'(snap_valid[0]), 32'd0);
            chk("stop_busy",   32'(snap_busy[0]),  32'd1);
            chk("valid",       32'(snap_valid[1]), 32'(vecs[v].exp_valid));
            chk("data",        32'(snap_data[1]),  32'(vecs[v].exp_valid ? vecs[v].exp_data : 8'h00));
            chk("level",       32'(snap_level[1]), 32'(vecs[v].exp_valid ? 1 : 0));
            chk("ferr_pulse",  32'(snap_ferr[1]),  32'(vecs[v].exp_ferr));
            chk("ferr_cycles", 32'(ferr_cnt),      32'(vecs[v].exp_ferr));
            chk("ovr_cycles",  32'(ovr_cnt),       32'd0);
            chk("idle_busy",   32'(snap_busy[1]),  32'd0);
            $display("[TB] frame tx=%02h stop=%0b valid=%0b data=%02h level=%0d ferr=%0d",
                     vecs[v].tx, vecs[v].stop, snap_valid[1], snap_data[1], snap_level[1], ferr_cnt);
            if (snap_valid[1]) begin
                pop_one();
                chk("pop_empty", 32'(data_valid), 32'd0);
            end
            idle(16);
        end

        // Glitch: low for 4 cycles only.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        chk("glitch_busy", 32'(rx_busy), 32'd1);
        ferr_cnt = 0;
        ovr_cnt  = 0;
        idle(24);
        chk("glitch_idle",  32'(rx_busy),   32'd0);
        chk("glitch_level", 32'(level),     32'd0);
        chk("glitch_ferr",  32'(ferr_cnt),  32'd0);
        $display("[TB] glitch: busy=%0b level=%0d ferr=%0d", rx_busy, level, ferr_cnt);

        // Overflow: five back-to-back frames with the consumer stalled.
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b1, -1);
            chk("fill_level", 32'(snap_level[1]), 32'(k < 4 ? k : 4));
            chk("fill_ovr",   32'(ovr_cnt),       32'(k == 5 ? 1 : 0));
            chk("fill_head",  32'(snap_data[1]),  32'd1);
            $display("[TB] fill tx=%02h level=%0d ovr=%0d", k, snap_level[1], ovr_cnt);
        end
        chk("ovr_pulse", 32'(snap_ovr[1]), 32'd1);
        for (int j = 0; j < 4; j++) begin
            chk("drain_valid", 32'(data_valid), 32'd1);
            chk("drain_data",  32'(data_out),   32'(j + 1));
            $display("[TB] drain data=%02h", data_out);
            data_ready = 1'b1;
            @(negedge clk);
        end
        data_ready = 1'b0;
        chk("drain_empty", 32'(data_valid), 32'd0);
        idle(16);

        // Full FIFO with a pop coinciding with the fifth push.
        for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, -1);
        chk("full_level", 32'(snap_level[1]), 32'd4);
        send_frame(8'h05, 1'b1, 154);
        chk("sp_ovr", 32'(ovr_cnt), 32'd0);
        for (int j = 0; j < 5; j++) begin
            chk("sp_valid", 32'(snap_valid[j]), 32'd1);
            chk("sp_data",  32'(snap_data[j]),  32'(j + 1));
            $display("[TB] simul read data=%02h", snap_data[j]);
        end
        chk("sp_level", 32'(snap_level[1]), 32'd4);
        chk("sp_empty", 32'(snap_valid[5]), 32'd0);
        data_ready = 1'b0;
        idle(16);

        // Reset mid-byte with a byte already queued.
        send_frame(8'h5A, 1'b1, -1);
        chk("pre_rst_level", 32'(snap_level[1]), 32'd1);
        idle(4);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_busy", 32'(rx_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        $display("[TB] mid-frame reset: valid=%0b level=%0d busy=%0b", data_valid, level, rx_busy);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(16);
        send_frame(8'hF0, 1'b1, -1);
        chk("post_rst_valid", 32'(snap_valid[1]), 32'd1);
        chk("post_rst_data",  32'(snap_data[1]),  32'hF0);
        chk("post_rst_level", 32'(snap_level[1]), 32'd1);
        $display("[TB] after reset tx=f0 data=%02h", snap_data[1]);
        pop_one();
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default `SERIAL_WCNT from the shared defines header, meaning clk cycles per serial bit (min 8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries (power of 2, min 2).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1.
REQ-006 SHALL have port data_out  output  8  byte at FIFO head.
REQ-007 SHALL have port data_valid  output  1  FIFO non-empty.
REQ-008 SHALL have port data_ready  input  1  consumer accepts data_out.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse on byte dropped because FIFO full.
REQ-011 SHALL have port rx_busy  output  1  frame in progress (state != IDLE).
REQ-012 SHALL have port level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value, 2-cycle latency.
REQ-014 SHALL implement states IDLE, START, DATA, STOP with one bit-timer counting 0..CLKS_PER_BIT-1.
REQ-015 IDLE: a synchronized 1->0 transition SHALL enter START with timer cleared; a line held low does not retrigger.
REQ-016 START: at timer == CLKS_PER_BIT/2-1, synchronized rx == 0 SHALL enter DATA with timer cleared; rx == 1 SHALL return to IDLE (glitch reject), no other effect.
REQ-017 DATA: SHALL sample once every CLKS_PER_BIT cycles (mid-bit), shift in LSB first, and enter STOP after the 8th sample.
REQ-018 STOP: at the mid-bit sample, rx == 1 SHALL push the byte into the FIFO; rx == 0 SHALL pulse frame_err for one cycle and discard the byte; both return to IDLE that cycle.
REQ-019 Push with FIFO full and no pop in the same cycle SHALL drop the byte, pulse overrun one cycle, and leave FIFO contents unchanged.
REQ-020 Push and pop in the same cycle while full SHALL succeed, no overrun, level unchanged.
REQ-021 Pop occurs when data_valid && data_ready; data_out SHALL hold stable while data_valid && !data_ready.
REQ-022 A pushed byte SHALL appear with data_valid high the cycle after the push (into empty FIFO); FIFO order is strictly first-in first-out.
REQ-023 Pointers SHALL wrap modulo FIFO_DEPTH; level = pushes - pops, range 0..FIFO_DEPTH.
REQ-024 frame_err and overrun SHALL never assert for more than one consecutive cycle per event; both may coincide only if a frame error occurs with an overrun, which is impossible since frame errors never push.
REQ-025 Total latency from stop-bit centre on rx pin to data_valid SHALL be 3 cycles (2 sync + 1 push).

Reset
REQ-026 On rst_n low, asynchronously: state IDLE, timer 0, shift register 0, sync flops 1, FIFO empty, data_valid 0, data_out 0, level 0, frame_err 0, overrun 0, rx_busy 0.
REQ-027 Reset mid-frame SHALL abandon the partial byte; after release the next valid start bit SHALL be received normally.

Structure
REQ-028 State encoding localparams and the default bit period SHALL live in the shared defines header, alongside SERIAL_WCNT.
REQ-029 The FIFO SHALL be a separate sub-module uart_rx_fifo (sync, parameterised depth/width, push/pop/full/empty/level).
REQ-030 Total RTL SHALL be 120-400 lines; no latches, no combinational path from rx to any output.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-031 Drive 0x55 as 8N1 at 16 cycles/bit -> data_valid high 3 cycles after stop-bit centre, data_out=0x55, level=1, no error pulses.
REQ-032 Drive rx low for 4 cycles then high -> returns to IDLE from START, no push, frame_err=0, level=0.
REQ-033 Drive 0xA3 with stop bit 0 -> one-cycle frame_err, level stays 0, next frame 0x3C received correctly.
REQ-034 data_ready=0, send 0x01..0x05 back-to-back -> level=4, one overrun pulse on 5th; then data_ready=1 -> reads 0x01,0x02,0x03,0x04, data_valid drops.
REQ-035 Full FIFO, data_ready=1 held across 5th stop-bit sample -> no overrun, 0x05 read after 0x04.
REQ-036 Assert rst_n low in DATA mid-byte -> all outputs at reset values immediately; after release send 0xF0 -> data_out=0xF0.
